// File: rtl/blit_loop_seq_pkg.sv
// Shared blitter definitions: loop sequencer states and B_COUNT field layout.
// B_COUNT holds the inner (pixel) count in the low field and the outer (line) count above it.
package blit_loop_seq_pkg;

    localparam int B_COUNT_INNER_LSB = 0;
    localparam int B_COUNT_INNER_W   = 16;
    localparam int B_COUNT_OUTER_LSB = B_COUNT_INNER_LSB + B_COUNT_INNER_W;
    localparam int B_COUNT_OUTER_W   = 16;

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        ILOAD,
        INNER,
        OSTEP,
        ODEC,
        OWAIT,
        DONE
    } blit_state_t;

endpackage

// File: rtl/blit_loop_seq_if.sv
// Signal bundle between the GPU register port, the outer line counter and the blitter datapath.
// The master side is the loop sequencer; the slave side is everything around it.
interface blit_loop_seq_if #(
    parameter int INNER_W = 16
) ();
    logic [31:0]        gpu_din;
    logic               count_wr;
    logic               go;
    logic               stop;
    logic               countld;
    logic               ocntena;
    logic               outer0;
    logic               pix_req;
    logic               pix_ack;
    logic               step_req;
    logic               step_ack;
    logic               busy;
    logic               done;
    logic [INNER_W-1:0] icount;

    modport master (
        input  gpu_din, count_wr, go, stop, outer0, pix_ack, step_ack,
        output countld, ocntena, pix_req, step_req, busy, done, icount
    );

    modport slave (
        output gpu_din, count_wr, go, stop, outer0, pix_ack, step_ack,
        input  countld, ocntena, pix_req, step_req, busy, done, icount
    );
endinterface

// File: rtl/blit_loop_seq_inner_cnt.sv
// Purpose: loadable inner (pixel) down-counter, wraps modulo 2^W, flags a count of one.
// Latency: load/decrement visible one cycle after the enabling cycle.
// Backpressure: none; the caller only decrements on an accepted pixel.
module blit_inner_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         is_one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec) begin
            count <= count - 1'b1;
        end
    end

    assign is_one = (count == W'(1));

endmodule

// File: rtl/blit_loop_seq.sv
// Purpose: sequences one blit's line/pixel loops, driving the outer counter and datapath handshakes.
// Latency: done 2 cycles after go for zero lines; otherwise 4 cycles of overhead per line plus handshakes.
// Backpressure: pix_req/step_req hold until acked; go and count_wr are dropped while busy.
module blit_loop_seq
    import blit_loop_seq_pkg::*;
#(
    parameter int INNER_W = B_COUNT_INNER_W,
    parameter int OUTER_W = B_COUNT_OUTER_W
) (
    input  logic            clk,
    input  logic            reset,
    blit_loop_seq_if.master bus
);

    blit_state_t        state;
    logic [INNER_W-1:0] shadow;
    logic               ocntena_q;
    logic               pix_req_q;
    logic               step_req_q;
    logic               busy_q;
    logic               done_q;

    logic [INNER_W-1:0] icnt;
    logic               icnt_one;
    logic               icnt_load;
    logic               icnt_dec;
    logic               abort;

    // The outer field is consumed by the external line counter, not here.
    logic unused_outer_field;
    assign unused_outer_field = ^bus.gpu_din[INNER_W+OUTER_W-1:INNER_W];

    assign icnt_load = (state == ILOAD);
    // A pixel acked in the same cycle as stop is still counted.
    assign icnt_dec  = (state == INNER) && bus.pix_ack;
    assign abort     = bus.stop && (state != IDLE) && (state != DONE);

    blit_inner_cnt #(.W(INNER_W)) u_inner_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (icnt_load),
        .load_val (shadow),
        .dec      (icnt_dec),
        .count    (icnt),
        .is_one   (icnt_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            ocntena_q  <= 1'b0;
            pix_req_q  <= 1'b0;
            step_req_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ocntena_q <= 1'b0;
            done_q    <= 1'b0;
            if (state == IDLE && bus.count_wr) begin
                shadow <= bus.gpu_din[INNER_W-1:0];
            end
            if (abort) begin
                state      <= DONE;
                pix_req_q  <= 1'b0;
                step_req_q <= 1'b0;
                done_q     <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.go) begin
                            state  <= CHK;
                            busy_q <= 1'b1;
                        end
                    end
                    CHK, OWAIT: begin
                        if (bus.outer0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= ILOAD;
                        end
                    end
                    ILOAD: begin
                        state     <= INNER;
                        pix_req_q <= 1'b1;
                    end
                    INNER: begin
                        if (bus.pix_ack && icnt_one) begin
                            state      <= OSTEP;
                            pix_req_q  <= 1'b0;
                            step_req_q <= 1'b1;
                        end
                    end
                    OSTEP: begin
                        if (bus.step_ack) begin
                            state      <= ODEC;
                            step_req_q <= 1'b0;
                            ocntena_q  <= 1'b1;
                        end
                    end
                    ODEC: begin
                        state <= OWAIT;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    // The outer counter samples gpu_din in the write cycle itself.
    assign bus.countld  = bus.count_wr && (state == IDLE) && !reset;
    assign bus.ocntena  = ocntena_q;
    assign bus.pix_req  = pix_req_q;
    assign bus.step_req = step_req_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.icount   = icnt;

endmodule
